bounce_generator: RTL and testbench

Synthesisable contact-bounce emulator: converts a clean command level into a deterministic, pseudo-randomly bouncing signal that settles to the commanded level. It is the driving end of the debouncer path. It feeds debouncer instances in benches and on-board self-test, so their filtering can be checked against reproducible bounce patterns.

---
 rtl/bounce_generator_pkg.sv | 31 +++
 rtl/bounce_generator_lfsr8.sv | 36 +++
 rtl/bounce_generator.sv | 128 ++++++++++++
 tb/tb_bounce_generator.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bounce_generator_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_generator_pkg
//  Description : Shared state encoding, LFSR constants and helper functions
//                for the contact-bounce emulator and related stimulus blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package bounce_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BOUNCE = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Taps at bits 7,5,4,3 of the 8-bit Fibonacci LFSR
    localparam logic [7:0] c_lfsr_taps    = 8'hB8;
    localparam logic [7:0] c_default_seed = 8'hA5;

    // One Fibonacci step: shift left, feedback enters at bit 0
    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & c_lfsr_taps)};
    endfunction

    // Bounce interval from the low gw bits of the LFSR, always 1..2^gw
    function automatic logic [8:0] gap_from_lfsr(input logic [7:0] l, input int gw);
        return {1'b0, l & (8'hFF >> (8 - gw))} + 9'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bounce_generator_lfsr8.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr8
//  Description : 8-bit Fibonacci LFSR, seed loaded on reset, steps only when
//                adv is high. An all-zero seed is replaced by 8'h01 so the
//                register can never lock up.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr8
    import bounce_generator_pkg::*;
#(
    parameter logic [7:0] SEED = c_default_seed
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    output logic [7:0] lfsr
);

    localparam logic [7:0] c_seed = (SEED == 8'h00) ? 8'h01 : SEED;

    logic [7:0] r_lfsr;

    // LFSR register: seed on reset, one step per advance request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= c_seed;
        end else if (adv) begin
            r_lfsr <= lfsr_next(r_lfsr);
        end
    end

    assign lfsr = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/bounce_generator.sv
`default_nettype none
// ============================================================================
//  Module      : bounce_generator
//  Description : Contact-bounce emulator. A change on cmd produces a clean
//                first edge, then BOUNCES glitch pairs spaced by LFSR-derived
//                gaps, then SETTLE stable cycles ending in a one-cycle done.
//  Revision    : 1.0 - initial release
// ============================================================================
module bounce_generator
    import bounce_generator_pkg::*;
#(
    parameter logic [7:0] SEED    = c_default_seed,
    parameter int         GW      = 3,
    parameter int         BOUNCES = 2,
    parameter int         SETTLE  = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic cmd,
    output logic out,
    output logic busy,
    output logic done
);

    localparam int            c_sw          = $clog2(SETTLE + 1);
    localparam logic [GW:0]   c_gap_one     = (GW+1)'(1);
    localparam logic [4:0]    c_rem_init    = 5'(2 * BOUNCES);
    localparam logic [c_sw-1:0] c_settle_init = c_sw'(SETTLE);
    localparam logic [c_sw-1:0] c_settle_one  = c_sw'(1);

    state_t          r_state;
    logic            r_out;
    logic            r_busy;
    logic            r_done;
    logic            r_level;
    logic            r_target;
    logic [GW:0]     r_gap;
    logic [4:0]      r_rem;
    logic [c_sw-1:0] r_settle;

    logic [7:0]      w_lfsr;
    logic            w_start;
    logic            w_adv;

    assign w_start = (r_state == ST_IDLE) && (cmd != r_level);

    // LFSR steps exactly when a gap is loaded: at a bouncing start, and on
    // every toggle that is not the last one
    assign w_adv = (w_start && (BOUNCES != 0)) ||
                   ((r_state == ST_BOUNCE) && (r_gap == c_gap_one) && (r_rem != 5'd1));

    lfsr8 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .adv  (w_adv),
        .lfsr (w_lfsr)
    );

    // Transition FSM with gap, remaining-toggle and settle counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_out    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_level  <= 1'b0;
            r_target <= 1'b0;
            r_gap    <= '0;
            r_rem    <= '0;
            r_settle <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_target <= cmd;
                        r_out    <= cmd;
                        r_busy   <= 1'b1;
                        r_rem    <= c_rem_init;
                        if (BOUNCES == 0) begin
                            r_settle <= c_settle_init;
                            r_state  <= ST_SETTLE;
                        end else begin
                            r_gap   <= (GW+1)'(gap_from_lfsr(w_lfsr, GW));
                            r_state <= ST_BOUNCE;
                        end
                    end
                end
                ST_BOUNCE: begin
                    if (r_gap == c_gap_one) begin
                        // Odd toggle count guarantees out lands on target
                        r_out <= ~r_out;
                        r_rem <= r_rem - 5'd1;
                        if (r_rem != 5'd1) begin
                            r_gap <= (GW+1)'(gap_from_lfsr(w_lfsr, GW));
                        end else begin
                            r_gap    <= '0;
                            r_settle <= c_settle_init;
                            r_state  <= ST_SETTLE;
                        end
                    end else begin
                        r_gap <= r_gap - c_gap_one;
                    end
                end
                ST_SETTLE: begin
                    r_settle <= r_settle - c_settle_one;
                    if (r_settle == c_settle_one) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_level <= r_target;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign out  = r_out;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_bounce_generator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bounce_generator
//  Description : Scoreboard bench for bounce_generator. Stimulus pushes the
//                hand-computed out/busy/done events of each transition; a
//                negedge monitor pops and compares every observed change.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bounce_generator;

    typedef struct {
        int   kind;   // 0 out change, 1 busy change, 2 done pulse
        int   cyc;
        logic val;
    } ev_t;

    logic clk;
    logic rst;
    logic cmd_a, cmd_b, cmd_c;
    logic out_a, busy_a, done_a;
    logic out_b, busy_b, done_b;
    logic out_c, busy_c, done_c;

    int   cyc;
    int   n_cmp;
    int   n_bad;
    ev_t  q_a[$];
    ev_t  q_b[$];
    ev_t  q_c[$];
    logic po[3];
    logic pb[3];

    // Closed-loop debouncer on the round-trip instance
    localparam int THR = 12;
    logic dbc;
    logic p_dbc;
    int   dcnt;
    int   dbc_changes;

    bounce_generator #(.SEED(8'hA5), .GW(3), .BOUNCES(1), .SETTLE(4)) u_dut_a (
        .clk(clk), .rst(rst), .cmd(cmd_a), .out(out_a), .busy(busy_a), .done(done_a));
    bounce_generator #(.SEED(8'hA5), .GW(3), .BOUNCES(0), .SETTLE(4)) u_dut_b (
        .clk(clk), .rst(rst), .cmd(cmd_b), .out(out_b), .busy(busy_b), .done(done_b));
    bounce_generator #(.SEED(8'hA5), .GW(3), .BOUNCES(2), .SETTLE(4)) u_dut_c (
        .clk(clk), .rst(rst), .cmd(cmd_c), .out(out_c), .busy(busy_c), .done(done_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            dbc  <= 1'b0;
            dcnt <= 0;
        end else if (out_c == dbc) begin
            dcnt <= 0;
        end else if (dcnt == THR - 1) begin
            dbc  <= out_c;
            dcnt <= 0;
        end else begin
            dcnt <= dcnt + 1;
        end
    end

    function automatic string kname(input int k);
        case (k)
            0:       return "out";
            1:       return "busy";
            default: return "done";
        endcase
    endfunction

    task automatic push(input int id, input int kind, input int c, input logic v);
        ev_t e;
        e.kind = kind; e.cyc = c; e.val = v;
        case (id)
            0:       q_a.push_back(e);
            1:       q_b.push_back(e);
            default: q_c.push_back(e);
        endcase
    endtask

    task automatic check_ev(input int id, input int kind, input int c, input logic v);
        ev_t e;
        bit  have;
        have = 0;
        case (id)
            0:       if (q_a.size() > 0) begin e = q_a.pop_front(); have = 1; end
            1:       if (q_b.size() > 0) begin e = q_b.pop_front(); have = 1; end
            default: if (q_c.size() > 0) begin e = q_c.pop_front(); have = 1; end
        endcase
        n_cmp++;
        if (!have) begin
            n_bad++;
            $display("FAIL dut%0d unexpected_event: got %s=%0b at cycle %0d, required none", id, kname(kind), v, c);
        end else if (e.kind != kind || e.cyc != c || e.val != v) begin
            n_bad++;
            $display("FAIL dut%0d event: got %s=%0b at cycle %0d, required %s=%0b at cycle %0d",
                     id, kname(kind), v, c, kname(e.kind), e.val, e.cyc);
        end
    endtask

    task automatic mon(input int id, input logic o, input logic b, input logic d);
        if (!rst) begin
            po[id] = o;
            pb[id] = b;
        end else begin
            if (o != po[id]) check_ev(id, 0, cyc, o);
            if (b != pb[id]) check_ev(id, 1, cyc, b);
            if (d)           check_ev(id, 2, cyc, 1'b1);
            po[id] = o;
            pb[id] = b;
        end
    endtask

    // Monitor: every change of out/busy and every done pulse is scored
    always @(negedge clk) begin
        mon(0, out_a, busy_a, done_a);
        mon(1, out_b, busy_b, done_b);
        mon(2, out_c, busy_c, done_c);
        if (rst && dbc != p_dbc) begin
            dbc_changes++;
            n_cmp++;
            if (busy_c || out_c != dbc) begin
                n_bad++;
                $display("FAIL debounce_early: got busy=%0b out=%0b at change to %0b, required busy=0 out=%0b",
                         busy_c, out_c, dbc, dbc);
            end
        end
        p_dbc = dbc;
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int id, input logic v, output int k);
        @(negedge clk);
        case (id)
            0:       cmd_a = v;
            1:       cmd_b = v;
            default: cmd_c = v;
        endcase
        k = cyc + 1;
    endtask

    task automatic push_done(input int id, input int c);
        push(id, 1, c, 1'b0);
        push(id, 2, c, 1'b1);
    endtask

    // Bounce pattern of the first transition from SEED A5 on dut A: gaps 6,3
    task automatic push_a_first(input int k);
        push(0, 0, k, 1'b1); push(0, 1, k, 1'b1);
        push(0, 0, k + 6, 1'b0);
        push(0, 0, k + 9, 1'b1);
        push_done(0, k + 13);
    endtask

    initial begin
        int k;
        cyc = 0; n_cmp = 0; n_bad = 0; dbc_changes = 0; p_dbc = 1'b0;
        po[0] = 0; po[1] = 0; po[2] = 0; pb[0] = 0; pb[1] = 0; pb[2] = 0;
        rst = 1'b0; cmd_a = 1'b0; cmd_b = 1'b0; cmd_c = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_out",  {31'd0, out_a},  32'd0);
        check_val("reset_busy", {31'd0, busy_a}, 32'd0);
        check_val("reset_done", {31'd0, done_a}, 32'd0);
        check_val("reset_lfsr", {24'd0, u_dut_a.u_lfsr.r_lfsr}, 32'hA5);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // T1: 0->1 with one glitch pair, gaps 6,3
        drive(0, 1'b1, k); push_a_first(k);
        repeat (16) @(negedge clk);
        check_val("level_after_t1", {31'd0, u_dut_a.r_level}, 32'd1);

        // T2: 1->0, cmd wiggles during BOUNCE but ends equal to target
        drive(0, 1'b0, k);
        push(0, 0, k, 1'b0); push(0, 1, k, 1'b1);
        push(0, 0, k + 6, 1'b1);
        push(0, 0, k + 9, 1'b0);
        push_done(0, k + 13);
        repeat (3) @(negedge clk); cmd_a = 1'b1;
        repeat (2) @(negedge clk); cmd_a = 1'b0;
        repeat (14) @(negedge clk);

        // T3: 0->1 (gaps 5,2), cmd drops mid-bounce so T4 follows the done edge
        drive(0, 1'b1, k);
        push(0, 0, k, 1'b1); push(0, 1, k, 1'b1);
        push(0, 0, k + 5, 1'b0);
        push(0, 0, k + 7, 1'b1);
        push_done(0, k + 11);
        push(0, 0, k + 12, 1'b0); push(0, 1, k + 12, 1'b1);
        push(0, 0, k + 16, 1'b1);
        push(0, 0, k + 24, 1'b0);
        push_done(0, k + 28);
        repeat (3) @(negedge clk); cmd_a = 1'b0;
        repeat (30) @(negedge clk);

        // T5: 0->1 (gaps 7,6) aborted by reset while settling
        drive(0, 1'b1, k);
        push(0, 0, k, 1'b1); push(0, 1, k, 1'b1);
        push(0, 0, k + 7, 1'b0);
        push(0, 0, k + 13, 1'b1);
        while (cyc < k + 14) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        check_val("midreset_out",  {31'd0, out_a},  32'd0);
        check_val("midreset_busy", {31'd0, busy_a}, 32'd0);
        check_val("midreset_done", {31'd0, done_a}, 32'd0);
        check_val("midreset_lfsr", {24'd0, u_dut_a.u_lfsr.r_lfsr}, 32'hA5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        k = cyc + 1;
        push_a_first(k);
        repeat (20) @(negedge clk);

        // No-bounce instance: clean edge, done after SETTLE, LFSR untouched
        drive(1, 1'b1, k);
        push(1, 0, k, 1'b1); push(1, 1, k, 1'b1);
        push_done(1, k + 4);
        repeat (7) @(negedge clk);
        check_val("nobounce_lfsr", {24'd0, u_dut_b.u_lfsr.r_lfsr}, 32'hA5);
        drive(1, 1'b0, k);
        push(1, 0, k, 1'b0); push(1, 1, k, 1'b1);
        push_done(1, k + 4);
        repeat (7) @(negedge clk);

        // Round trip with two glitch pairs: gaps 6,3,6,3 up, then 5,2,4,8 down
        drive(2, 1'b1, k);
        push(2, 0, k, 1'b1); push(2, 1, k, 1'b1);
        push(2, 0, k + 6, 1'b0);
        push(2, 0, k + 9, 1'b1);
        push(2, 0, k + 15, 1'b0);
        push(2, 0, k + 18, 1'b1);
        push_done(2, k + 22);
        repeat (38) @(negedge clk);
        check_val("roundtrip_level_up", {31'd0, u_dut_c.r_level}, 32'd1);
        check_val("debounce_up", {31'd0, dbc}, 32'd1);
        drive(2, 1'b0, k);
        push(2, 0, k, 1'b0); push(2, 1, k, 1'b1);
        push(2, 0, k + 5, 1'b1);
        push(2, 0, k + 7, 1'b0);
        push(2, 0, k + 11, 1'b1);
        push(2, 0, k + 19, 1'b0);
        push_done(2, k + 23);
        repeat (40) @(negedge clk);
        check_val("roundtrip_level_down", {31'd0, u_dut_c.r_level}, 32'd0);
        check_val("debounce_changes", dbc_changes, 32'd2);

        check_val("pending_a", q_a.size(), 32'd0);
        check_val("pending_b", q_b.size(), 32'd0);
        check_val("pending_c", q_c.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
